jtframe_dwnld_pack: RTL and testbench
=====================================

# jtframe_dwnld_pack

Byte-to-word packer and write buffer between the MiSTer ROM download port and the SDRAM programming port. It consumes the 8-bit `ioctl_*` write stream and merges byte pairs into 16-bit masked words. It maps each word to an SDRAM bank and bank-relative word address, buffers it, and drives `prog_*` towards `jtframe_board`. It reports `dwnld_busy` until every byte has been written to SDRAM.

## Interface
- `BA1_START`, 25'h10_0000: first byte address mapped to bank 1.
- `BA2_START`, 25'h20_0000: first byte address mapped to bank 2; must be ≥ `BA1_START`.
- `BA3_START`, 25'h30_0000: first byte address mapped to bank 3; must be ≥ `BA2_START`.
- `FIFO_AW`, 3: log2 of the word FIFO depth (default 8 entries).

Ports:
- `clk` in 1: ROM/download clock. One clock; reset is synchronous and active-low.
- `rst_n` in 1: synchronous active-low reset.
- `downloading` in 1: ROM download in progress (index 0).
- `ioctl_addr` in 25: byte address.
- `ioctl_data` in 8: byte data.
- `ioctl_rom_wr` in 1: one-cycle byte strobe.
- `prog_addr` out 22: bank-relative word address.
- `prog_data` out 16: word data.
- `prog_mask` out 2: byte disable, active high; bit 0 = low byte, bit 1 = high byte.
- `prog_ba` out 2: bank.
- `prog_we` out 1: write request.
- `prog_rdy` in 1: one-cycle acknowledge from SDRAM.
- `dwnld_busy` out 1: download or drain in progress.
- `ovf` out 1: sticky FIFO overflow flag.

## Operation
- Staging register: holds one byte address `sa`, one data byte and a valid flag (`sv`).
- Byte arrival, byte address `A`:
  - If `sv`, `sa` is even and `A == sa+1`: push the merged word with mask 00. Staging becomes empty.
  - Else if `sv`: push the staged byte alone, then load `A` into staging.
  - Else: load `A` into staging.
- A single-byte word has the byte copied to both halves. Mask is 10 for an even address and 01 for an odd address.
- Push rule: at most one push per cycle.
- Flush: on the falling edge of `downloading`, a valid staging entry is pushed the next cycle.
- Bank mapping: the first matching condition, checked from bank 3 down, gives the bank.
  - `A ≥ BA3_START` → bank 3, else `A ≥ BA2_START` → bank 2, else `A ≥ BA1_START` → bank 1, else bank 0.
  - `prog_addr = (A − bank_start) >> 1`, truncated to 22 bits.
- FIFO full at push time: the word is dropped and `ovf` is set.
- `ovf` clears only on a rising edge of `downloading` or on reset.
- A rising edge of `downloading` also clears staging without pushing.
- Output FSM, two states:
  - IDLE: when the FIFO is non-empty, load the head onto `prog_*`, assert `prog_we` and go to WAIT.
  - WAIT: hold all `prog_*` stable. On `prog_rdy`, pop the FIFO, drop `prog_we` the next cycle and return to IDLE.
- `dwnld_busy = downloading | sv | FIFO non-empty | prog_we`.

## Timing
- Reset values:
  - `prog_we`=0, `prog_addr`=0, `prog_data`=0, `prog_mask`=2'b11, `prog_ba`=0.
  - `ovf`=0, `dwnld_busy`=0 (while `downloading`=0).
  - FIFO empty, staging invalid, FSM in IDLE.
- Latency: push happens on the byte-arrival edge. With an empty FIFO, `prog_we` rises 2 cycles after the `ioctl_rom_wr` cycle.
- `prog_we` is low for at least one cycle between consecutive words.
- Push and pop in the same cycle are allowed.
- A push when the FIFO is full and a pop happens in the same cycle is accepted; no overflow is flagged.
- `prog_rdy` while in IDLE is ignored.
- Reset mid-transfer abandons the current word and all buffered words immediately.
- `dwnld_busy` falls the cycle after the last `prog_rdy`, provided `downloading` is already low.

## Configuration
- `JTFRAME_DWNLD_SWAB_EN` defined: the even-address byte goes to `prog_data[7:0]` and the odd byte to `[15:8]`. Mask bits swap to match: even-only gives 10, odd-only gives 01, both unchanged.
- Not defined: the even-address byte goes to `[15:8]` and the odd byte to `[7:0]`. Mask: even-only gives 01, odd-only gives 10.
- The Operation section describes the defined (swapped) case.

## Structure
- Package `jtframe_dwnld_pkg`:
  - FSM state enum (IDLE, WAIT).
  - FIFO entry struct {ba[1:0], addr[21:0], mask[1:0], data[15:0]}.
  - Mask constants.
- Sub-module `jtframe_dwnld_fifo`: synchronous single-clock FIFO of entry structs, depth 2^`FIFO_AW`, with full/empty flags and first-word-fall-through read.
- The top handles staging, bank mapping and the output FSM.

## Test plan
- Bytes 0x12 @0, 0x34 @1, `prog_rdy` one cycle after `prog_we` → one write: ba 0, addr 0, mask 00, data 0x3412 with SWAB, 0x1234 without.
- Byte 0xAA @0x100001 alone, then `downloading` falls → write: ba 1, addr 0, data 0xAAAA, mask 01 with SWAB; `dwnld_busy` then falls.
- Bytes @4, then @8 → two single-byte writes: addr 2 and addr 4, each mask 10 with SWAB.
- 20 word pairs with `prog_rdy` held low → 8 writes accepted, `ovf`=1; a new `downloading` rising edge clears `ovf`.
- Byte @0x300002 → ba 3, addr 1.
- `rst_n` low while in WAIT → next cycle `prog_we`=0, FIFO empty, `dwnld_busy`=0.

Source files
------------

// File: rtl/jtframe_dwnld_pkg.sv
// Shared types, mask constants and helpers for the download packer.
// Byte lane order is selected by JTFRAME_DWNLD_SWAB_EN (defined: even byte in [7:0]).
package jtframe_dwnld_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fsm_state_t;

    typedef struct packed {
        logic [1:0]  ba;
        logic [21:0] addr;
        logic [1:0]  mask;
        logic [15:0] data;
    } dwnld_entry_t;

    localparam logic [1:0] MASK_BOTH = 2'b00;
    localparam logic [1:0] MASK_NONE = 2'b11;

`ifdef JTFRAME_DWNLD_SWAB_EN
    localparam logic [1:0] MASK_EVEN_ONLY = 2'b10;
    localparam logic [1:0] MASK_ODD_ONLY  = 2'b01;
`else
    localparam logic [1:0] MASK_EVEN_ONLY = 2'b01;
    localparam logic [1:0] MASK_ODD_ONLY  = 2'b10;
`endif

    function automatic logic [15:0] pack_pair(input logic [7:0] even_byte,
                                              input logic [7:0] odd_byte);
`ifdef JTFRAME_DWNLD_SWAB_EN
        return {odd_byte, even_byte};
`else
        return {even_byte, odd_byte};
`endif
    endfunction

    // Highest bank whose start address the byte address has reached.
    function automatic logic [1:0] bank_sel(input logic [24:0] addr,
                                            input logic [24:0] ba1_start,
                                            input logic [24:0] ba2_start,
                                            input logic [24:0] ba3_start);
        if (addr >= ba3_start)      return 2'd3;
        else if (addr >= ba2_start) return 2'd2;
        else if (addr >= ba1_start) return 2'd1;
        else                        return 2'd0;
    endfunction

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Single-clock first-word-fall-through FIFO of packed SDRAM write entries.
// The caller never pushes into a full FIFO unless it pops in the same cycle.
module jtframe_dwnld_fifo
    import jtframe_dwnld_pkg::*;
#(
    parameter int FIFO_AW = 3
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  dwnld_entry_t din,
    input  logic         pop,
    output dwnld_entry_t dout,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << FIFO_AW;

    dwnld_entry_t       mem [DEPTH];
    logic [FIFO_AW:0]   wr_ptr;
    logic [FIFO_AW:0]   rd_ptr;

    // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
        end
    end

    assign dout  = mem[rd_ptr[FIFO_AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

endmodule

// File: rtl/jtframe_dwnld_pack.sv
// Packs the 8-bit ioctl download stream into masked 16-bit SDRAM words per bank.
// Lane order follows JTFRAME_DWNLD_SWAB_EN (see jtframe_dwnld_pkg).
module jtframe_dwnld_pack
    import jtframe_dwnld_pkg::*;
#(
    parameter logic [24:0] BA1_START = 25'h10_0000,
    parameter logic [24:0] BA2_START = 25'h20_0000,
    parameter logic [24:0] BA3_START = 25'h30_0000,
    parameter int          FIFO_AW   = 3
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_rom_wr,
    output logic [21:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic [1:0]  prog_ba,
    output logic        prog_we,
    input  logic        prog_rdy,
    output logic        dwnld_busy,
    output logic        ovf
);

    fsm_state_t   state;
    logic         dl_l;
    logic         sv;
    logic [24:0]  sa;
    logic [7:0]   sd;

    logic         dl_rise;
    logic         sv_eff;
    logic         merge;
    logic         push_req;
    logic         push_ok;
    logic         drop;
    logic [1:0]   map_ba;
    logic [24:0]  map_base;
    logic [24:0]  map_off;
    dwnld_entry_t push_entry;

    dwnld_entry_t fifo_dout;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_pop;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        dl_rise  = downloading & ~dl_l;
        // A new download discards any byte left over from the previous one.
        sv_eff   = sv & ~dl_rise;
        merge    = ioctl_rom_wr & sv_eff & ~sa[0] & (ioctl_addr == sa + 25'd1);
        // Staged byte leaves on any non-merging arrival, or once the download has ended.
        push_req = sv_eff & (ioctl_rom_wr | ~downloading);

        map_ba = bank_sel(sa, BA1_START, BA2_START, BA3_START);
        case (map_ba)
            2'd3:    map_base = BA3_START;
            2'd2:    map_base = BA2_START;
            2'd1:    map_base = BA1_START;
            default: map_base = '0;
        endcase
        map_off = sa - map_base;

        push_entry.ba   = map_ba;
        push_entry.addr = 22'(map_off >> 1);
        if (merge) begin
            push_entry.mask = MASK_BOTH;
            push_entry.data = pack_pair(sd, ioctl_data);
        end else begin
            push_entry.mask = sa[0] ? MASK_ODD_ONLY : MASK_EVEN_ONLY;
            push_entry.data = {sd, sd};
        end

        // A pop in the same cycle frees the slot a full FIFO needs.
        push_ok = push_req & (~fifo_full | fifo_pop);
        drop    = push_req & fifo_full & ~fifo_pop;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dl_l <= 1'b0;
            sv   <= 1'b0;
            sa   <= '0;
            sd   <= '0;
            ovf  <= 1'b0;
        end else begin
            dl_l <= downloading;

            if (dl_rise)   ovf <= 1'b0;
            else if (drop) ovf <= 1'b1;

            if (ioctl_rom_wr && !merge) begin
                sv <= 1'b1;
                sa <= ioctl_addr;
                sd <= ioctl_data;
            end else if (merge || push_req || dl_rise) begin
                sv <= 1'b0;
            end
        end
    end

    jtframe_dwnld_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fifo_pop = (state == ST_WAIT) && prog_rdy;

    // The head stays in the FIFO while it is presented; it is popped on acknowledge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= MASK_NONE;
            prog_ba   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        prog_ba   <= fifo_dout.ba;
                        prog_addr <= fifo_dout.addr;
                        prog_mask <= fifo_dout.mask;
                        prog_data <= fifo_dout.data;
                        prog_we   <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (prog_rdy) begin
                        prog_we <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    prog_we <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign dwnld_busy = downloading | sv | ~fifo_empty | prog_we;

endmodule

// File: tb/tb_jtframe_dwnld_pack.sv
// Directed self-checking bench for jtframe_dwnld_pack; honours JTFRAME_DWNLD_SWAB_EN.
module tb_jtframe_dwnld_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_rom_wr = 1'b0;
    logic        prog_rdy = 1'b0;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic [1:0]  prog_ba;
    logic        prog_we;
    logic        dwnld_busy;
    logic        ovf;

    int total = 0;
    int bad   = 0;

`ifdef JTFRAME_DWNLD_SWAB_EN
    localparam logic [1:0] M_EVEN = 2'b10;
    localparam logic [1:0] M_ODD  = 2'b01;
    function automatic logic [15:0] exp_word(input logic [7:0] ev, input logic [7:0] od);
        return {od, ev};
    endfunction
`else
    localparam logic [1:0] M_EVEN = 2'b01;
    localparam logic [1:0] M_ODD  = 2'b10;
    function automatic logic [15:0] exp_word(input logic [7:0] ev, input logic [7:0] od);
        return {ev, od};
    endfunction
`endif

    always #5 clk = ~clk;

    jtframe_dwnld_pack dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .downloading  (downloading),
        .ioctl_addr   (ioctl_addr),
        .ioctl_data   (ioctl_data),
        .ioctl_rom_wr (ioctl_rom_wr),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .prog_mask    (prog_mask),
        .prog_ba      (prog_ba),
        .prog_we      (prog_we),
        .prog_rdy     (prog_rdy),
        .dwnld_busy   (dwnld_busy),
        .ovf          (ovf)
    );

    // Returns one negedge into the cycle after the strobe.
    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk);
        ioctl_addr   = a;
        ioctl_data   = d;
        ioctl_rom_wr = 1'b1;
        @(negedge clk);
        ioctl_rom_wr = 1'b0;
    endtask

    // Waits (bounded) for prog_we, captures the word and acknowledges it one cycle later.
    task automatic get_write(input int budget, output logic ok, output logic [1:0] ba,
                             output logic [21:0] addr, output logic [1:0] mask,
                             output logic [15:0] data);
        ok = 1'b0; ba = '0; addr = '0; mask = '0; data = '0;
        for (int i = 0; i < budget; i++) begin
            if (prog_we) begin
                ok = 1'b1; ba = prog_ba; addr = prog_addr; mask = prog_mask; data = prog_data;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(negedge clk);
            prog_rdy = 1'b1;
            @(negedge clk);
            prog_rdy = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++; if (prog_we !== 1'b0)     begin bad++; $display("FAIL reset_we got=%b want=0", prog_we); end
        total++; if (prog_mask !== 2'b11)  begin bad++; $display("FAIL reset_mask got=%b want=11", prog_mask); end
        total++; if (prog_addr !== 22'd0 || prog_data !== 16'd0 || prog_ba !== 2'd0)
                 begin bad++; $display("FAIL reset_word got=%h/%h/%h want=0/0/0", prog_ba, prog_addr, prog_data); end
        total++; if (ovf !== 1'b0)         begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        total++; if (dwnld_busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b want=0", dwnld_busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_word_pair;
        logic ok; logic [1:0] ba; logic [21:0] addr; logic [1:0] mask; logic [15:0] data;
        @(negedge clk);
        downloading = 1'b1;
        send_byte(25'd0, 8'h12);
        send_byte(25'd1, 8'h34);
        total++; if (prog_we !== 1'b0) begin bad++; $display("FAIL pair_lat1 got=%b want=0", prog_we); end
        @(negedge clk);
        total++; if (prog_we !== 1'b1) begin bad++; $display("FAIL pair_lat2 got=%b want=1", prog_we); end
        get_write(50, ok, ba, addr, mask, data);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL pair_timeout got=%b want=1", ok); end
        total++; if (ba !== 2'd0 || addr !== 22'd0)
                 begin bad++; $display("FAIL pair_addr got=%0d/%h want=0/0", ba, addr); end
        total++; if (mask !== 2'b00) begin bad++; $display("FAIL pair_mask got=%b want=00", mask); end
        total++; if (data !== exp_word(8'h12, 8'h34))
                 begin bad++; $display("FAIL pair_data got=%h want=%h", data, exp_word(8'h12, 8'h34)); end
        total++; if (prog_we !== 1'b0) begin bad++; $display("FAIL pair_we_drop got=%b want=0", prog_we); end
    endtask

    task automatic test_flush_odd;
        logic ok; logic [1:0] ba; logic [21:0] addr; logic [1:0] mask; logic [15:0] data;
        send_byte(25'h10_0001, 8'hAA);
        total++; if (prog_we !== 1'b0 || dwnld_busy !== 1'b1)
                 begin bad++; $display("FAIL flush_staged got=we%b/busy%b want=we0/busy1", prog_we, dwnld_busy); end
        downloading = 1'b0;
        get_write(50, ok, ba, addr, mask, data);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL flush_timeout got=%b want=1", ok); end
        total++; if (ba !== 2'd1 || addr !== 22'd0)
                 begin bad++; $display("FAIL flush_addr got=%0d/%h want=1/0", ba, addr); end
        total++; if (mask !== M_ODD || data !== 16'hAAAA)
                 begin bad++; $display("FAIL flush_word got=%b/%h want=%b/aaaa", mask, data, M_ODD); end
        total++; if (dwnld_busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", dwnld_busy); end
    endtask

    task automatic test_single_bytes;
        logic ok; logic [1:0] ba; logic [21:0] addr; logic [1:0] mask; logic [15:0] data;
        @(negedge clk);
        downloading = 1'b1;
        send_byte(25'd4, 8'h55);
        send_byte(25'd8, 8'h66);
        @(negedge clk);
        downloading = 1'b0;
        get_write(50, ok, ba, addr, mask, data);
        total++; if (ok !== 1'b1 || ba !== 2'd0 || addr !== 22'd2 || mask !== M_EVEN || data !== 16'h5555)
                 begin bad++; $display("FAIL single_a got=%b %0d/%h %b %h want=1 0/2 %b 5555", ok, ba, addr, mask, data, M_EVEN); end
        get_write(50, ok, ba, addr, mask, data);
        total++; if (ok !== 1'b1 || ba !== 2'd0 || addr !== 22'd4 || mask !== M_EVEN || data !== 16'h6666)
                 begin bad++; $display("FAIL single_b got=%b %0d/%h %b %h want=1 0/4 %b 6666", ok, ba, addr, mask, data, M_EVEN); end
    endtask

    task automatic test_overflow;
        logic ok; logic [1:0] ba; logic [21:0] addr; logic [1:0] mask; logic [15:0] data;
        int n;
        logic seq_ok;
        @(negedge clk);
        downloading = 1'b1;
        for (int k = 0; k < 20; k++) begin
            send_byte(25'(2*k),     8'(k));
            send_byte(25'(2*k + 1), 8'(k + 8'h80));
        end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", ovf); end
        n = 0;
        seq_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            get_write(40, ok, ba, addr, mask, data);
            if (!ok) break;
            if (ba !== 2'd0 || addr !== 22'(n) || mask !== 2'b00 || data !== exp_word(8'(n), 8'(n + 8'h80)))
                seq_ok = 1'b0;
            n++;
        end
        total++; if (n != 8) begin bad++; $display("FAIL ovf_count got=%0d want=8", n); end
        total++; if (seq_ok !== 1'b1) begin bad++; $display("FAIL ovf_order got=%b want=1", seq_ok); end
        downloading = 1'b0;
        @(negedge clk);
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", ovf); end
        downloading = 1'b1;
        @(negedge clk);
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", ovf); end
    endtask

    task automatic test_bank3;
        logic ok; logic [1:0] ba; logic [21:0] addr; logic [1:0] mask; logic [15:0] data;
        send_byte(25'h30_0002, 8'h5A);
        downloading = 1'b0;
        get_write(50, ok, ba, addr, mask, data);
        total++; if (ok !== 1'b1 || ba !== 2'd3 || addr !== 22'd1)
                 begin bad++; $display("FAIL bank3_addr got=%b %0d/%h want=1 3/1", ok, ba, addr); end
        total++; if (mask !== M_EVEN || data !== 16'h5A5A)
                 begin bad++; $display("FAIL bank3_word got=%b/%h want=%b/5a5a", mask, data, M_EVEN); end
    endtask

    task automatic test_reset_mid;
        logic seen;
        @(negedge clk);
        downloading = 1'b1;
        send_byte(25'h10, 8'h01);
        send_byte(25'h11, 8'h02);
        send_byte(25'h12, 8'h03);
        send_byte(25'h13, 8'h04);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (prog_we) seen = 1'b1;
            else @(negedge clk);
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rstmid_wait got=%b want=1", seen); end
        rst_n = 1'b0;
        downloading = 1'b0;
        @(negedge clk);
        total++; if (prog_we !== 1'b0 || dwnld_busy !== 1'b0)
                 begin bad++; $display("FAIL rstmid_state got=we%b/busy%b want=we0/busy0", prog_we, dwnld_busy); end
        total++; if (prog_mask !== 2'b11 || prog_addr !== 22'd0)
                 begin bad++; $display("FAIL rstmid_word got=%b/%h want=11/0", prog_mask, prog_addr); end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (prog_we || dwnld_busy) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_quiet got=%b want=0", seen); end
    endtask

    initial begin
        test_reset();
        test_word_pair();
        test_flush_odd();
        test_single_bytes();
        test_overflow();
        test_bank3();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
